// File: rtl/sweep_check_pkg.sv
// Shared types and constants for the logic-implementation sweep checker.
package sweep_check_pkg;

    localparam int unsigned NUM_VEC = 16;
    localparam int unsigned VEC_W   = 4;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned DWELL_W = 8;
    localparam int unsigned MASK_W  = 3;

    // mismatch_mask bit positions
    localparam int unsigned MASK_NAIVE_MINTERM   = 0;
    localparam int unsigned MASK_NAIVE_MAXTERM   = 1;
    localparam int unsigned MASK_MINTERM_MAXTERM = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with a rising-edge pulse; usable for any button input.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_c
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    // Synchroniser chain plus previous-value flop
    always_comb begin
        s1_d   = async_in;
        s2_d   = s1_q;
        s3_d   = s2_q;
        rise_c = s2_q & ~s3_q;
    end

    // Flop update, async active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

endmodule

// File: rtl/sweep_check_ctrl.sv
// Self-test sequencer: sweeps A..D through all 16 vectors, compares the three
// Y outputs per vector and reports pass/fail, first failure and minterm count.
// Optional macro STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module sweep_check_ctrl #(
    parameter int unsigned DWELL   = 4,
    parameter int unsigned NUM_VEC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_naive,
    input  logic       y_minterm,
    input  logic       y_maxterm,
    output logic [3:0] vec,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail,
    output logic [3:0] fail_vec,
    output logic [2:0] mismatch_mask,
    output logic [4:0] ones_count
);

    import sweep_check_pkg::*;

    localparam logic [VEC_W-1:0]   LAST_VEC  = VEC_W'(NUM_VEC - 1);
    localparam logic [DWELL_W-1:0] DWELL_END = DWELL_W'(DWELL - 1);

    state_t              state_q, state_d;
    logic [VEC_W-1:0]    vec_q, vec_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                fail_q, fail_d;
    logic                fail_seen_q, fail_seen_d;
    logic [VEC_W-1:0]    fail_vec_q, fail_vec_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]    ones_q, ones_d;

    logic                rise_c;
    logic                agree_c;
    logic                term_c;
    logic [MASK_W-1:0]   mask_now_c;

    sync_edge u_start_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (start),
        .rise_c   (rise_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        dwell_d     = dwell_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        fail_seen_d = fail_seen_q;
        fail_vec_d  = fail_vec_q;
        mask_d      = mask_q;
        ones_d      = ones_q;
        term_c      = 1'b0;

        agree_c = (y_naive == y_minterm) && (y_naive == y_maxterm);
        mask_now_c = '0;
        mask_now_c[MASK_NAIVE_MINTERM]   = y_naive ^ y_minterm;
        mask_now_c[MASK_NAIVE_MAXTERM]   = y_naive ^ y_maxterm;
        mask_now_c[MASK_MINTERM_MAXTERM] = y_minterm ^ y_maxterm;

        case (state_q)
            IDLE, DONE: begin
                if (rise_c) begin
                    state_d     = APPLY;
                    vec_d       = '0;
                    dwell_d     = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_seen_d = 1'b0;
                    fail_vec_d  = '0;
                    mask_d      = '0;
                    ones_d      = '0;
                end
            end
            APPLY: begin
                dwell_d = dwell_q + DWELL_W'(1);
                if (dwell_q == DWELL_END) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                term_c = (vec_q == LAST_VEC);
                if (agree_c) begin
                    ones_d = ones_q + CNT_W'(y_naive);
                end else if (!fail_seen_q) begin
                    fail_seen_d = 1'b1;
                    fail_vec_d  = vec_q;
                    mask_d      = mask_now_c;
`ifdef STOP_ON_FAIL_EN
                    term_c      = 1'b1;
`endif
                end
                if (term_c) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = ~fail_seen_d;
                    fail_d  = fail_seen_d;
                end else begin
                    state_d = APPLY;
                    vec_d   = vec_q + VEC_W'(1);
                    dwell_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            dwell_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_seen_q <= 1'b0;
            fail_vec_q  <= '0;
            mask_q      <= '0;
            ones_q      <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            dwell_q     <= dwell_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            fail_seen_q <= fail_seen_d;
            fail_vec_q  <= fail_vec_d;
            mask_q      <= mask_d;
            ones_q      <= ones_d;
        end
    end

    assign vec           = vec_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail          = fail_q;
    assign fail_vec      = fail_vec_q;
    assign mismatch_mask = mask_q;
    assign ones_count    = ones_q;

endmodule

// File: tb/tb_sweep_check_ctrl.sv
// Bench for sweep_check_ctrl: the three implementations are truth tables driven
// from vec; expected results come from a direct walk over those tables.
module tb_sweep_check_ctrl;

    localparam int unsigned DWELL = 4;
    localparam int unsigned PER   = DWELL + 1;
    localparam logic [15:0] F_REF = 16'h2AAA;   // sum m(1,3,5,7,9,11,13)

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] tt_n, tt_mi, tt_mx;
    logic        y_naive, y_minterm, y_maxterm;
    logic [3:0]  vec;
    logic        busy, done, pass, fail;
    logic [3:0]  fail_vec;
    logic [2:0]  mismatch_mask;
    logic [4:0]  ones_count;

    int          n_checks;
    int          n_pass;

    logic        e_fail;
    logic [3:0]  e_fail_vec;
    logic [2:0]  e_mask;
    logic [4:0]  e_ones;
    int          e_last;

    assign y_naive   = tt_n[vec];
    assign y_minterm = tt_mi[vec];
    assign y_maxterm = tt_mx[vec];

    sweep_check_ctrl #(.DWELL(DWELL), .NUM_VEC(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .y_naive       (y_naive),
        .y_minterm     (y_minterm),
        .y_maxterm     (y_maxterm),
        .vec           (vec),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail          (fail),
        .fail_vec      (fail_vec),
        .mismatch_mask (mismatch_mask),
        .ones_count    (ones_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected sweep results straight from the three truth tables
    task automatic model();
        int  ones;
        bit  failed;
        bit  n, mi, mx;
        ones       = 0;
        failed     = 1'b0;
        e_last     = 15;
        e_fail_vec = '0;
        e_mask     = '0;
        for (int v = 0; v < 16; v++) begin
            n  = tt_n[v];
            mi = tt_mi[v];
            mx = tt_mx[v];
            if (n == mi && mi == mx) begin
                ones += int'(n);
            end else if (!failed) begin
                failed     = 1'b1;
                e_fail_vec = 4'(v);
                e_mask     = {mi ^ mx, n ^ mx, n ^ mi};
`ifdef STOP_ON_FAIL_EN
                e_last = v;
                break;
`endif
            end
        end
        e_fail = failed;
        e_ones = 5'(ones);
    endtask

    // Launch one sweep, track vec/busy every cycle, then check the results
    task automatic run_sweep(input string tag, input bit poke_busy);
        int total;
        model();
        start = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            n_checks++;
            if (busy !== (e == 3)) $display("FAIL %s launch_busy edge%0d: got %b want %b", tag, e, busy, (e == 3));
            else n_pass++;
        end
        start = 1'b0;
        n_checks++;
        if ({done, pass, fail, ones_count, fail_vec, mismatch_mask} !== '0)
            $display("FAIL %s results_cleared: got done=%b pass=%b fail=%b ones=%0d fv=%0d mask=%b want all 0",
                     tag, done, pass, fail, ones_count, fail_vec, mismatch_mask);
        else n_pass++;

        total = (e_last + 1) * int'(PER);
        for (int k = 0; k < total; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            n_checks++;
            if (vec !== 4'(k / int'(PER)) || busy !== 1'b1 || done !== 1'b0)
                $display("FAIL %s step k=%0d: got vec=%0d busy=%b done=%b want vec=%0d busy=1 done=0",
                         tag, k, vec, busy, done, k / int'(PER));
            else n_pass++;
            if (poke_busy && k == 6 * int'(PER)) start = 1'b1;
            if (poke_busy && k == 6 * int'(PER) + 3) start = 1'b0;
        end

        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL %s done_flags: got done=%b busy=%b want done=1 busy=0", tag, done, busy);
        else n_pass++;
        n_checks++;
        if (pass !== ~e_fail || fail !== e_fail)
            $display("FAIL %s verdict: got pass=%b fail=%b want pass=%b fail=%b", tag, pass, fail, ~e_fail, e_fail);
        else n_pass++;
        n_checks++;
        if (ones_count !== e_ones)
            $display("FAIL %s ones_count: got %0d want %0d", tag, ones_count, e_ones);
        else n_pass++;
        n_checks++;
        if (fail_vec !== e_fail_vec || mismatch_mask !== e_mask)
            $display("FAIL %s first_fail: got vec=%0d mask=%b want vec=%0d mask=%b",
                     tag, fail_vec, mismatch_mask, e_fail_vec, e_mask);
        else n_pass++;
        n_checks++;
        if (vec !== 4'(e_last))
            $display("FAIL %s final_vec: got %0d want %0d", tag, vec, e_last);
        else n_pass++;

        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ones_count !== e_ones)
            $display("FAIL %s done_hold: got done=%b busy=%b ones=%0d want done=1 busy=0 ones=%0d",
                     tag, done, busy, ones_count, e_ones);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        tt_n  = F_REF;
        tt_mi = F_REF;
        tt_mx = F_REF;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({vec, busy, done, pass, fail, fail_vec, mismatch_mask, ones_count} !== '0)
            $display("FAIL reset_async: got vec=%0d busy=%b done=%b pass=%b fail=%b fv=%0d mask=%b ones=%0d want all 0",
                     vec, busy, done, pass, fail, fail_vec, mismatch_mask, ones_count);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || vec !== 4'd0 || done !== 1'b0)
            $display("FAIL reset_idle: got busy=%b vec=%0d done=%b want 0 0 0", busy, vec, done);
        else n_pass++;
    endtask

    task automatic test_agree();
        tt_n  = F_REF;
        tt_mi = F_REF;
        tt_mx = F_REF;
        run_sweep("agree", 1'b0);
        n_checks++;
        if (ones_count !== 5'd7 || pass !== 1'b1)
            $display("FAIL agree_const: got ones=%0d pass=%b want 7 1", ones_count, pass);
        else n_pass++;
    endtask

    task automatic test_single_fault();
        tt_n  = F_REF;
        tt_mi = F_REF;
        tt_mx = F_REF ^ 16'h0200;
        run_sweep("single_fault", 1'b0);
        n_checks++;
`ifdef STOP_ON_FAIL_EN
        if (fail_vec !== 4'd9 || mismatch_mask !== 3'b110 || ones_count !== 5'd4 || vec !== 4'd9)
`else
        if (fail_vec !== 4'd9 || mismatch_mask !== 3'b110 || ones_count !== 5'd6)
`endif
            $display("FAIL single_const: got fv=%0d mask=%b ones=%0d vec=%0d", fail_vec, mismatch_mask, ones_count, vec);
        else n_pass++;
    endtask

    task automatic test_multi_fault();
        tt_n  = F_REF ^ 16'h1004;
        tt_mi = F_REF;
        tt_mx = F_REF;
        run_sweep("multi_fault", 1'b0);
        n_checks++;
        if (fail_vec !== 4'd2 || mismatch_mask !== 3'b011)
            $display("FAIL multi_const: got fv=%0d mask=%b want 2 011", fail_vec, mismatch_mask);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        tt_n  = F_REF;
        tt_mi = F_REF ^ 16'h0001;
        tt_mx = F_REF;
        run_sweep("busy_poke", 1'b1);
        tt_mi = F_REF;
        run_sweep("after_done", 1'b0);
    endtask

    task automatic test_reset_mid_sweep();
        tt_n  = F_REF;
        tt_mi = F_REF;
        tt_mx = F_REF;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        repeat (10 * PER + 2) @(posedge clk);
        #1;
        n_checks++;
        if (vec !== 4'd10 || busy !== 1'b1)
            $display("FAIL midrst_pre: got vec=%0d busy=%b want 10 1", vec, busy);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({vec, busy, done, pass, fail, fail_vec, mismatch_mask, ones_count} !== '0)
            $display("FAIL midrst_clear: got vec=%0d busy=%b done=%b ones=%0d want all 0", vec, busy, done, ones_count);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || vec !== 4'd0 || done !== 1'b0)
            $display("FAIL midrst_idle: got busy=%b vec=%0d done=%b want 0 0 0", busy, vec, done);
        else n_pass++;
        run_sweep("after_reset", 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] base;
        for (int i = 0; i < 6; i++) begin
            base  = 16'($urandom);
            tt_n  = base ^ (($urandom_range(0, 2) == 0) ? (16'd1 << $urandom_range(0, 15)) : 16'd0);
            tt_mi = base ^ (($urandom_range(0, 2) == 0) ? (16'd1 << $urandom_range(0, 15)) : 16'd0);
            tt_mx = base ^ (($urandom_range(0, 2) == 0) ? (16'd1 << $urandom_range(0, 15)) : 16'd0);
            run_sweep($sformatf("random%0d", i), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_agree();
        test_single_fault();
        test_multi_fault();
        test_back_to_back();
        test_reset_mid_sweep();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
